// File: rtl/md_byte_framer.sv
// rtl/md_byte_framer.sv - packs an 8-bit AXI-S byte stream into 32-bit tagged words plus end-of-frame marker
// Optional XOR checksum in the marker: define MD_FRAMER_CHECKSUM_EN.
module md_byte_framer #(
    parameter int MAX_WORDS  = 255,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [15:0]                   frame_count,
    output logic [15:0]                   trunc_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int WCW = $clog2(MAX_WORDS + 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_MARK    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]     state;
    logic           running;
    logic [1:0]     lane;
    logic [7:0]     b0, b1;
    logic [WCW-1:0] word_cnt;
    logic [9:0]     byte_cnt;
    logic           trunc;
    logic [7:0]     chk;

    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           fifo_full;
    logic           wr_en, rd_en;
    logic [31:0]    wr_data;

    logic           accept;
    logic           need_word;
    logic           at_limit;
    logic           mark_done;
    logic [31:0]    data_word;

    assign fifo_full     = (count == (AW+1)'(FIFO_DEPTH));
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 32'h0;
    assign fifo_level    = count;
    assign rd_en         = m_axis_tvalid && m_axis_tready;

    // running keeps tready low while reset is asserted, since state alone reads as COLLECT
    assign s_axis_tready = running && ((state == S_COLLECT) ? !fifo_full : (state == S_DISCARD));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign need_word     = (state == S_COLLECT) && accept && ((lane == 2'd2) || s_axis_tlast);
    assign at_limit      = (word_cnt == WCW'(MAX_WORDS - 1));
    assign mark_done     = (state == S_MARK) && !fifo_full;
    assign wr_en         = (need_word && !at_limit) || mark_done;
    assign wr_data       = (state == S_MARK) ? {8'hFF, chk, trunc, 5'b0, byte_cnt} : data_word;

    always_comb begin
        data_word = 32'h0;
        case (lane)
            2'd0:    data_word = {8'h01, s_axis_tdata, 16'h0};
            2'd1:    data_word = {8'h02, b0, s_axis_tdata, 8'h0};
            default: data_word = {8'h03, b0, b1, s_axis_tdata};
        endcase
    end

`ifdef MD_FRAMER_CHECKSUM_EN
    logic [7:0] chk_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chk_acc <= 8'h00;
        else if (mark_done)
            chk_acc <= 8'h00;
        else if (need_word && !at_limit)
            chk_acc <= chk_acc ^ data_word[23:16] ^ data_word[15:8] ^ data_word[7:0];
    end
    assign chk = chk_acc;
`else
    assign chk = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            state       <= S_COLLECT;
            lane        <= 2'd0;
            b0          <= 8'h00;
            b1          <= 8'h00;
            word_cnt    <= '0;
            byte_cnt    <= 10'd0;
            trunc       <= 1'b0;
            frame_count <= 16'h0;
            trunc_count <= 16'h0;
        end else begin
            running <= 1'b1;
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        if (need_word) begin
                            lane <= 2'd0;
                            if (at_limit) begin
                                trunc <= 1'b1;
                                state <= s_axis_tlast ? S_MARK : S_DISCARD;
                            end else begin
                                word_cnt <= word_cnt + WCW'(1);
                                byte_cnt <= byte_cnt + {8'h00, lane} + 10'd1;
                                if (s_axis_tlast)
                                    state <= S_MARK;
                            end
                        end else begin
                            if (lane == 2'd0)
                                b0 <= s_axis_tdata;
                            else
                                b1 <= s_axis_tdata;
                            lane <= lane + 2'd1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (accept && s_axis_tlast)
                        state <= S_MARK;
                end
                S_MARK: begin
                    if (!fifo_full) begin
                        frame_count <= frame_count + 16'h1;
                        if (trunc)
                            trunc_count <= trunc_count + 16'h1;
                        word_cnt <= '0;
                        byte_cnt <= 10'd0;
                        trunc    <= 1'b0;
                        lane     <= 2'd0;
                        state    <= S_COLLECT;
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // storage needs no reset: tdata is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_md_byte_framer.sv
// tb/tb_md_byte_framer.sv - directed self-checking bench for md_byte_framer
module tb_md_byte_framer;
`ifdef MD_FRAMER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, sel, m_tready;
    logic        rdy0, rdy1, s_tready;
    logic [31:0] m0_tdata, m1_tdata;
    logic        m0_tvalid, m1_tvalid;
    logic [15:0] frame0, trunc0, frame1, trunc1;
    logic [3:0]  level0, level1;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit sender_done;

    always #5 clk = ~clk;

    assign s_tready = sel ? rdy1 : rdy0;

    md_byte_framer u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tlast(s_tlast),
        .s_axis_tready(rdy0),
        .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m_tready),
        .frame_count(frame0), .trunc_count(trunc0), .fifo_level(level0)
    );

    md_byte_framer #(.MAX_WORDS(4)) u_trunc (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tlast(s_tlast),
        .s_axis_tready(rdy1),
        .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m_tready),
        .frame_count(frame1), .trunc_count(trunc1), .fifo_level(level1)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_tvalid && m_tready) q0.push_back(m0_tdata);
            if (m1_tvalid && m_tready) q1.push_back(m1_tdata);
        end
    end

    function automatic logic [7:0] ck(input logic [7:0] v);
        return CK ? v : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input int which, input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = 'x;
        if (which == 0 && q0.size() > 0) obs = q0.pop_front();
        if (which == 1 && q1.size() > 0) obs = q1.pop_front();
        chk(tag, obs, exp);
    endtask

    task automatic wait_q(input int which, input int n);
        for (int k = 0; k < 400; k++) begin
            if ((which == 0 ? q0.size() : q1.size()) >= n) break;
            @(posedge clk);
        end
        #1;
        chk("queue_len", (which == 0 ? q0.size() : q1.size()), n);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", {31'b0, s_tready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; m_tready = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", {31'b0, rdy0}, 32'd0);
        chk("rst_tvalid", {31'b0, m0_tvalid}, 32'd0);
        chk("rst_tdata", m0_tdata, 32'h0);
        chk("rst_frame", {16'h0, frame0}, 32'd0);
        chk("rst_trunc", {16'h0, trunc0}, 32'd0);
        chk("rst_level", {28'h0, level0}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_tready", {31'b0, rdy0}, 32'd1);

        // 1: four bytes
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
        s_tvalid = 1'b0;
        wait_q(0, 3);
        chk_q(0, "t1_w0", 32'h03112233);
        chk_q(0, "t1_w1", 32'h01440000);
        chk_q(0, "t1_mark", {8'hFF, ck(8'h44), 16'h0004});
        chk("t1_frames", {16'h0, frame0}, 32'd1);

        // 2: single-byte frame, tready low for exactly the MARK cycle
        send_byte(8'hAA, 1);
        s_tvalid = 1'b0;
        chk("t2_mark_tready", {31'b0, rdy0}, 32'd0);
        @(posedge clk); #1;
        chk("t2_after_tready", {31'b0, rdy0}, 32'd1);
        wait_q(0, 2);
        chk_q(0, "t2_w0", 32'h01AA0000);
        chk_q(0, "t2_mark", {8'hFF, ck(8'hAA), 16'h0001});
        chk("t2_frames", {16'h0, frame0}, 32'd2);

        // 3: back-pressure fills the FIFO
        m_tready = 1'b0; sender_done = 1'b0;
        fork
            begin
                for (int i = 1; i <= 30; i++) send_byte(8'(i), i == 30);
                s_tvalid = 1'b0;
                sender_done = 1'b1;
            end
        join_none
        for (int k = 0; k < 300 && level0 != 4'd8; k++) @(negedge clk);
        chk("t3_level_full", {28'h0, level0}, 32'd8);
        chk("t3_tready_low", {31'b0, rdy0}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t3_level_hold", {28'h0, level0}, 32'd8);
        @(posedge clk); #1 m_tready = 1'b1;
        for (int k = 0; k < 400 && !sender_done; k++) @(posedge clk);
        wait_q(0, 11);
        for (int w = 0; w < 10; w++)
            chk_q(0, "t3_word", {8'h03, 8'(3*w+1), 8'(3*w+2), 8'(3*w+3)});
        chk_q(0, "t3_mark", {8'hFF, ck(8'h1F), 16'h001E});

        // 4: truncation on the MAX_WORDS=4 instance
        @(posedge clk); #1 sel = 1'b1;
        for (int i = 1; i <= 12; i++) send_byte(8'(i), i == 12);
        s_tvalid = 1'b0;
        wait_q(1, 4);
        chk_q(1, "t4_w0", 32'h03010203);
        chk_q(1, "t4_w1", 32'h03040506);
        chk_q(1, "t4_w2", 32'h03070809);
        chk_q(1, "t4_mark", {8'hFF, ck(8'h01), 16'h8009});
        chk("t4_trunc_count", {16'h0, trunc1}, 32'd1);
        chk("t4_frames", {16'h0, frame1}, 32'd1);
        sel = 1'b0;

        // 5: reset mid-frame
        m_tready = 1'b0;
        send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0);
        send_byte(8'h88, 0); send_byte(8'h99, 0);
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        chk("t5_pre_level", {28'h0, level0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_level", {28'h0, level0}, 32'd0);
        chk("t5_tvalid", {31'b0, m0_tvalid}, 32'd0);
        chk("t5_frames", {16'h0, frame0}, 32'd0);
        chk("t5_trunc1", {16'h0, trunc1}, 32'd0);
        chk("t5_tready", {31'b0, rdy0}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; m_tready = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 1);
        s_tvalid = 1'b0;
        wait_q(0, 2);
        chk_q(0, "t5_w0", 32'h03A1B2C3);
        chk_q(0, "t5_mark", {8'hFF, ck(8'hD0), 16'h0003});
        repeat (3) @(posedge clk); #1;
        chk("t5_no_extra", q0.size(), 0);

        // 6: back-to-back frames with tvalid held high
        send_byte(8'h01, 0); send_byte(8'h02, 1);
        send_byte(8'h03, 0); send_byte(8'h04, 0); send_byte(8'h05, 0); send_byte(8'h06, 1);
        send_byte(8'h07, 1);
        s_tvalid = 1'b0;
        wait_q(0, 7);
        chk_q(0, "t6_a0", 32'h02010200);
        chk_q(0, "t6_amark", {8'hFF, ck(8'h03), 16'h0002});
        chk_q(0, "t6_b0", 32'h03030405);
        chk_q(0, "t6_b1", 32'h01060000);
        chk_q(0, "t6_bmark", {8'hFF, ck(8'h04), 16'h0004});
        chk_q(0, "t6_c0", 32'h01070000);
        chk_q(0, "t6_cmark", {8'hFF, ck(8'h07), 16'h0001});
        chk("t6_frames", {16'h0, frame0}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
